// File: rtl/dmem_pipe_if.sv
// Request/response bundle between the MEM stage and the dmem_pipe data RAM.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; the
// response comes back as a single resp_valid pulse, in order, and is never back-pressured.
interface dmem_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, init_done
  );
endinterface

// File: rtl/dmem_pipe.sv
// Word-organised RV32 data RAM with byte-lane stores, a LOAD_LAT-deep in-order
// response pipeline, error reporting and a post-reset memory clear.
module dmem_pipe #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LOAD_LAT  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  dmem_pipe_if.slave  bus,
  output logic        fsm_state
);
  localparam int AW   = $clog2(MEM_WORDS);
  localparam int LAST = LOAD_LAT - 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic            ready, init_done;

  logic [31:0]     mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    init_done = 1'b0;
    case (state)
      ST_INIT: if (clr_cnt == AW'(MEM_WORDS - 1)) state_nxt = ST_RUN;
      ST_RUN: begin
        ready     = 1'b1;
        init_done = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign fsm_state     = state;
  assign bus.req_ready = ready;
  assign bus.init_done = init_done;

  // Request decode. BASE_ADDR is word aligned, so the word offset is a 30-bit subtract.
  logic [29:0]   word_off;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [2:0]    f3;
  logic          range_err, f3_err, align_err, req_err;
  logic          accept, store_en;
  logic [3:0]    be;
  logic [31:0]   wd;

  always_comb begin
    word_off  = bus.req_addr[31:2] - BASE_ADDR[31:2];
    widx      = word_off[AW-1:0];
    lane      = bus.req_addr[1:0];
    f3        = bus.req_funct3;
    range_err = (bus.req_addr < BASE_ADDR) || (word_off >= 30'(MEM_WORDS));
    if (bus.req_we) f3_err = !(f3 inside {3'b000, 3'b001, 3'b010});
    else            f3_err =  (f3 inside {3'b011, 3'b110, 3'b111});
    align_err = ((f3[1:0] == 2'b01) && lane[0]) ||
                ((f3[1:0] == 2'b10) && (lane != 2'b00));
    req_err   = range_err | f3_err | align_err;
    accept    = bus.req_valid & ready;
    store_en  = accept & bus.req_we & !req_err;

    be = 4'b0000;
    wd = '0;
    case (f3[1:0])
      2'b00: begin be = 4'b0001 << lane;                    wd = {4{bus.req_wdata[7:0]}};  end
      2'b01: begin be = lane[1] ? 4'b1100 : 4'b0011;        wd = {2{bus.req_wdata[15:0]}}; end
      2'b10: begin be = 4'b1111;                            wd = bus.req_wdata;            end
      default: begin be = 4'b0000;                          wd = '0;                       end
    endcase
  end

  // Clear and store share the write port; they never overlap since ready=0 in INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == ST_INIT) begin
        mem[clr_cnt] <= '0;
      end else if (store_en) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  logic [LOAD_LAT-1:0] p_valid, p_err, p_we;
  logic [31:0]         p_word [LOAD_LAT];
  logic [2:0]          p_f3   [LOAD_LAT];
  logic [1:0]          p_lane [LOAD_LAT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      p_valid <= '0;
    end else begin
      p_valid[0] <= accept;
      for (int i = 1; i < LOAD_LAT; i++) p_valid[i] <= p_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    p_word[0] <= mem[widx];
    p_f3[0]   <= f3;
    p_lane[0] <= lane;
    p_err[0]  <= req_err;
    p_we[0]   <= bus.req_we;
    for (int i = 1; i < LOAD_LAT; i++) begin
      p_word[i] <= p_word[i-1];
      p_f3[i]   <= p_f3[i-1];
      p_lane[i] <= p_lane[i-1];
      p_err[i]  <= p_err[i-1];
      p_we[i]   <= p_we[i-1];
    end
  end

  // Lane extraction and extension happen only at the last stage.
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ext;

  always_comb begin
    bsel = p_word[LAST][{p_lane[LAST], 3'b000} +: 8];
    hsel = p_lane[LAST][1] ? p_word[LAST][31:16] : p_word[LAST][15:0];
    case (p_f3[LAST])
      3'b000:  ext = {{24{bsel[7]}}, bsel};
      3'b001:  ext = {{16{hsel[15]}}, hsel};
      3'b010:  ext = p_word[LAST];
      3'b100:  ext = {24'd0, bsel};
      3'b101:  ext = {16'd0, hsel};
      default: ext = '0;
    endcase
    bus.resp_valid = p_valid[LAST];
    bus.resp_err   = p_valid[LAST] & p_err[LAST];
    bus.resp_rdata = (p_valid[LAST] && !p_err[LAST] && !p_we[LAST]) ? ext : '0;
  end
endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench: two DUTs (LOAD_LAT 1 and 3, 16 words) share one request stream;
// each has an in-order expected queue stamped with the acceptance cycle.
module tb_dmem_pipe;
  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        st1, st3;
  logic        mon_en = 1'b0;
  logic        push3  = 1'b1;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // {accept cycle[64:33], err[32], rdata[31:0]}
  logic [64:0] exp_q1[$];
  logic [64:0] exp_q3[$];
  logic [64:0] e1, e3;

  dmem_pipe_if ifc1 ();
  dmem_pipe_if ifc3 ();

  assign ifc1.req_valid  = req_valid;
  assign ifc1.req_we     = req_we;
  assign ifc1.req_funct3 = req_funct3;
  assign ifc1.req_addr   = req_addr;
  assign ifc1.req_wdata  = req_wdata;
  assign ifc3.req_valid  = req_valid;
  assign ifc3.req_we     = req_we;
  assign ifc3.req_funct3 = req_funct3;
  assign ifc3.req_addr   = req_addr;
  assign ifc3.req_wdata  = req_wdata;

  dmem_pipe #(.MEM_WORDS(16), .LOAD_LAT(1), .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .reset(rst1), .bus(ifc1), .fsm_state(st1));
  dmem_pipe #(.MEM_WORDS(16), .LOAD_LAT(3), .BASE_ADDR(32'h0)) dut3 (
    .clk(clk), .reset(rst3), .bus(ifc3), .fsm_state(st3));

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp1,
                        input logic [31:0] exp3, input logic err);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    exp_q1.push_back({32'(cyc), err, exp1});
    if (push3) exp_q3.push_back({32'(cyc), err, exp3});
    req_valid = 1'b0;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
    do_req(1'b0, f3, addr, 32'h0, exp, exp, 1'b0);
  endtask
  task automatic ld_err(input logic [2:0] f3, input logic [31:0] addr);
    do_req(1'b0, f3, addr, 32'h0, 32'h0, 32'h0, 1'b1);
  endtask
  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    do_req(1'b1, f3, addr, wdata, 32'h0, 32'h0, 1'b0);
  endtask
  task automatic st_err(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    do_req(1'b1, f3, addr, wdata, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    idle(5);
    check({tag, "_q1_left"}, 32'(exp_q1.size()), 32'd0);
    check({tag, "_q3_left"}, 32'(exp_q3.size()), 32'd0);
  endtask

  // scoreboard monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc1.resp_valid) begin
        if (exp_q1.size() == 0) check("d1_unexpected_resp", 32'(ifc1.resp_valid), 32'd0);
        else begin
          e1 = exp_q1.pop_front();
          check("d1_rdata", ifc1.resp_rdata, e1[31:0]);
          check("d1_err",   32'(ifc1.resp_err), 32'(e1[32]));
          check("d1_cycle", 32'(cyc), e1[64:33]);
        end
      end else begin
        check("d1_idle_zero", ifc1.resp_rdata | 32'(ifc1.resp_err), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc3.resp_valid) begin
        if (exp_q3.size() == 0) check("d3_unexpected_resp", 32'(ifc3.resp_valid), 32'd0);
        else begin
          e3 = exp_q3.pop_front();
          check("d3_rdata", ifc3.resp_rdata, e3[31:0]);
          check("d3_err",   32'(ifc3.resp_err), 32'(e3[32]));
          check("d3_cycle", 32'(cyc), e3[64:33] + 32'd2);
        end
      end else begin
        check("d3_idle_zero", ifc3.resp_rdata | 32'(ifc3.resp_err), 32'd0);
      end
    end
  end

  initial begin
    rst1 = 1'b0; rst3 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;

    // reset state
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_ready1", 32'(ifc1.req_ready), 32'd0);
    check("rst_ready3", 32'(ifc3.req_ready), 32'd0);
    check("rst_done1",  32'(ifc1.init_done), 32'd0);
    check("rst_done3",  32'(ifc3.init_done), 32'd0);
    check("rst_rvalid1", 32'(ifc1.resp_valid), 32'd0);
    check("rst_rvalid3", 32'(ifc3.resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b1; rst3 = 1'b1;

    // clear takes exactly 16 cycles
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("init_ready1", 32'(ifc1.req_ready), 32'd0);
      check("init_ready3", 32'(ifc3.req_ready), 32'd0);
    end
    @(negedge clk);
    check("run_ready1", 32'(ifc1.req_ready), 32'd1);
    check("run_done1",  32'(ifc1.init_done), 32'd1);
    check("run_ready3", 32'(ifc3.req_ready), 32'd1);
    check("run_done3",  32'(ifc3.init_done), 32'd1);

    // every word cleared
    for (int w = 0; w < 16; w++) ld(3'b010, 32'(w * 4), 32'h0);
    drain("clear");

    // lane extraction, back-to-back, load directly after store
    st(3'b010, 32'h10, 32'h8765_43F0);
    ld(3'b000, 32'h10, 32'hFFFF_FFF0);
    ld(3'b100, 32'h10, 32'h0000_00F0);
    ld(3'b000, 32'h11, 32'h0000_0043);
    ld(3'b100, 32'h11, 32'h0000_0043);
    ld(3'b000, 32'h12, 32'h0000_0065);
    ld(3'b000, 32'h13, 32'hFFFF_FF87);
    ld(3'b100, 32'h13, 32'h0000_0087);
    ld(3'b001, 32'h10, 32'h0000_43F0);
    ld(3'b001, 32'h12, 32'hFFFF_8765);
    ld(3'b101, 32'h10, 32'h0000_43F0);
    ld(3'b101, 32'h12, 32'h0000_8765);
    ld(3'b010, 32'h10, 32'h8765_43F0);
    drain("lanes");

    // byte/half merges with read-after-write
    st(3'b010, 32'h20, 32'h1122_3344);
    st(3'b000, 32'h21, 32'h1234_56AA);
    ld(3'b010, 32'h20, 32'h1122_AA44);
    st(3'b001, 32'h22, 32'h7777_BEEF);
    ld(3'b010, 32'h20, 32'hBEEF_AA44);
    ld(3'b101, 32'h22, 32'h0000_BEEF);
    ld(3'b001, 32'h22, 32'hFFFF_BEEF);
    ld(3'b000, 32'h21, 32'hFFFF_FFAA);
    st(3'b000, 32'h23, 32'h0000_005A);
    ld(3'b010, 32'h20, 32'h5AEF_AA44);
    drain("merge");

    // errors
    ld_err(3'b010, 32'h22);
    st_err(3'b001, 32'h05, 32'h0000_DEAD);
    ld_err(3'b010, 32'h40);
    ld(3'b010, 32'h04, 32'h0);
    ld_err(3'b001, 32'h03);
    ld_err(3'b010, 32'h13);
    ld_err(3'b011, 32'h10);
    ld_err(3'b110, 32'h10);
    ld_err(3'b111, 32'h10);
    st_err(3'b100, 32'h10, 32'hFFFF_FFFF);
    st_err(3'b011, 32'h14, 32'hFFFF_FFFF);
    ld_err(3'b010, 32'hFFFF_FFFC);
    ld(3'b010, 32'h10, 32'h8765_43F0);
    ld(3'b010, 32'h14, 32'h0);
    drain("errors");

    // five loads, then reset dut3 during its third response
    ld(3'b010, 32'h10, 32'h8765_43F0);
    ld(3'b010, 32'h20, 32'h5AEF_AA44);
    ld(3'b010, 32'h00, 32'h0);
    ld(3'b100, 32'h13, 32'h0000_0087);
    ld(3'b001, 32'h12, 32'hFFFF_8765);
    rst3 = 1'b0;
    @(posedge clk); #1;
    check("d3_dropped_cnt", 32'(exp_q3.size()), 32'd2);
    exp_q3.delete();
    rst3 = 1'b1;
    push3 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("reinit_ready3", 32'(ifc3.req_ready), 32'd0);
      check("reinit_done3",  32'(ifc3.init_done), 32'd0);
    end
    @(negedge clk);
    check("rerun_ready3", 32'(ifc3.req_ready), 32'd1);
    check("rerun_done3",  32'(ifc3.init_done), 32'd1);
    check("d1_still_run", 32'(ifc1.req_ready), 32'd1);
    push3 = 1'b1;

    // dut3 memory cleared again, dut1 untouched
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8765_43F0, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h5AEF_AA44, 32'h0, 1'b0);
    drain("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
